// File: rtl/tone_pkg.sv
// Shared tone definitions: note code width, period counter width and the
// note -> nominal half-period table used by both the tone generator and decoder.
package tone_pkg;

    localparam int unsigned NOTE_W    = 5;
    localparam int unsigned PERIOD_W  = 19;
    localparam int unsigned NUM_NOTES = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SEARCH,
        ST_EVAL
    } dec_state_t;

    // Nominal half-period in clk cycles; entries 29/30 are intentionally out of order.
    function automatic logic [PERIOD_W-1:0] note_half_period(input logic [NOTE_W-1:0] code);
        logic [PERIOD_W-1:0] hp;
        hp = '0;
        case (code)
            5'd0:  hp = 19'd50000;
            5'd1:  hp = 19'd53000;
            5'd2:  hp = 19'd56000;
            5'd3:  hp = 19'd60000;
            5'd4:  hp = 19'd63000;
            5'd5:  hp = 19'd67000;
            5'd6:  hp = 19'd70000;
            5'd7:  hp = 19'd75000;
            5'd8:  hp = 19'd80000;
            5'd9:  hp = 19'd85000;
            5'd10: hp = 19'd90000;
            5'd11: hp = 19'd95000;
            5'd12: hp = 19'd100000;
            5'd13: hp = 19'd107000;
            5'd14: hp = 19'd113000;
            5'd15: hp = 19'd120000;
            5'd16: hp = 19'd127000;
            5'd17: hp = 19'd135000;
            5'd18: hp = 19'd143000;
            5'd19: hp = 19'd150000;
            5'd20: hp = 19'd160000;
            5'd21: hp = 19'd170000;
            5'd22: hp = 19'd180000;
            5'd23: hp = 19'd192000;
            5'd24: hp = 19'd203000;
            5'd25: hp = 19'd215000;
            5'd26: hp = 19'd227000;
            5'd27: hp = 19'd240000;
            5'd28: hp = 19'd254000;
            5'd29: hp = 19'd286000;
            5'd30: hp = 19'd270000;
            5'd31: hp = 19'd290000;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Half-period meter: synchronises audio_in, detects either edge and measures
// the clk cycles between consecutive edges; flags loss of tone.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   audio_in     asynchronous square wave
//   hp_done      1-cycle pulse, a new half-period is available on period
//   period       last measured half-period (cycles)
//   timeout_c    counter sits at TIMEOUT with no edge this cycle (combinational)
//   no_tone      high after reset / timeout until the next edge
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int unsigned TIMEOUT = 400000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_in,
    output logic                hp_done,
    output logic [PERIOD_W-1:0] period,
    output logic                timeout_c,
    output logic                no_tone
);

    logic [1:0]          sync_q;
    logic                prev_q;
    logic                edge_c;
    logic [PERIOD_W-1:0] cnt_q;

    assign edge_c    = sync_q[1] ^ prev_q;
    assign timeout_c = !edge_c && (cnt_q == PERIOD_W'(TIMEOUT));

    // Synchroniser, edge capture and saturating half-period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            hp_done <= 1'b0;
            period  <= '0;
            cnt_q   <= '0;
            no_tone <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], audio_in};
            prev_q  <= sync_q[1];
            hp_done <= edge_c;
            if (edge_c) begin
                period  <= cnt_q;
                cnt_q   <= PERIOD_W'(1);
                no_tone <= 1'b0;
            end else begin
                if (cnt_q < PERIOD_W'(TIMEOUT)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (timeout_c) begin
                    no_tone <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder: turns measured speaker half-periods back into a note code,
// requiring STABLE_CNT consecutive matching half-periods before reporting.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   audio_in      square wave, asynchronous to clk
//   note          decoded note code, held while note_valid
//   note_valid    stable tone of code note present
//   note_strobe   1-cycle pulse on valid rise or note change while valid
//   no_tone       no edge for TIMEOUT cycles (and after reset)
//   period_raw    (TONE_DEC_DEBUG_EN only) last captured half-period
//   miss_cnt      (TONE_DEC_DEBUG_EN only) saturating count of misses/aborts
// TBL_SHIFT right-shifts every nominal table entry (0 = real table); it lets a
// scaled-down tone be used without touching the shared table.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int unsigned TOL        = 1000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned TIMEOUT    = 400000,
    parameter int unsigned TBL_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              audio_in,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              note_strobe,
`ifdef TONE_DEC_DEBUG_EN
    output logic              no_tone,
    output logic [18:0]       period_raw,
    output logic [7:0]        miss_cnt
`else
    output logic              no_tone
`endif
);

    localparam int unsigned RUN_W = $clog2(STABLE_CNT + 1);

    logic                hp_done;
    logic [PERIOD_W-1:0] period_q;
    logic                timeout_c;

    tone_period_meter #(
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clk       (clk),
        .rst_n     (rst_n),
        .audio_in  (audio_in),
        .hp_done   (hp_done),
        .period    (period_q),
        .timeout_c (timeout_c),
        .no_tone   (no_tone)
    );

    dec_state_t        state_q, state_d;
    logic [NOTE_W-1:0] idx_q, idx_d;
    logic              hit_q, hit_d;
    logic [NOTE_W-1:0] hit_idx_q, hit_idx_d;
    logic [NOTE_W-1:0] cand_q, cand_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;
`ifdef TONE_DEC_DEBUG_EN
    logic [7:0]        miss_q, miss_d;
`endif
    logic              miss_c;

    logic [PERIOD_W-1:0] tbl_c;
    logic [PERIOD_W-1:0] diff_c;
    logic                match_c;

    // One table entry compared per SEARCH cycle
    assign tbl_c   = note_half_period(idx_q) >> TBL_SHIFT;
    assign diff_c  = (period_q >= tbl_c) ? (period_q - tbl_c) : (tbl_c - period_q);
    assign match_c = (diff_c <= PERIOD_W'(TOL));

    // Next-state: search sequencing, stability filter, output updates
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        cand_d    = cand_q;
        run_d     = run_q;
        note_d    = note_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        miss_c    = 1'b0;

        if (timeout_c) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            run_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hp_done) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (hp_done) begin
                        state_d = ST_SEARCH;
                        idx_d   = '0;
                        hit_d   = 1'b0;
                    end
                end
                ST_SEARCH: begin
                    if (hp_done) begin
                        // Half-period shorter than a search: counts as a miss, rescan new period
                        idx_d   = '0;
                        hit_d   = 1'b0;
                        run_d   = '0;
                        valid_d = 1'b0;
                        miss_c  = 1'b1;
                    end else begin
                        if (match_c && !hit_q) begin
                            hit_d     = 1'b1;
                            hit_idx_d = idx_q;
                        end
                        idx_d = idx_q + 1'b1;
                        if (idx_q == NOTE_W'(NUM_NOTES - 1)) begin
                            state_d = ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    if (hit_q) begin
                        if (hit_idx_q == cand_q) begin
                            if (run_q < RUN_W'(STABLE_CNT)) begin
                                run_d = run_q + 1'b1;
                            end
                        end else begin
                            cand_d = hit_idx_q;
                            run_d  = RUN_W'(1);
                        end
                    end else begin
                        run_d  = '0;
                        miss_c = 1'b1;
                    end
                    valid_d = (run_d >= RUN_W'(STABLE_CNT));
                    if (run_d >= RUN_W'(STABLE_CNT)) begin
                        note_d   = cand_d;
                        strobe_d = !valid_q || (note_q != cand_d);
                    end
                    // An edge landing on the EVAL cycle starts the next search directly
                    if (hp_done) begin
                        state_d = ST_SEARCH;
                        idx_d   = '0;
                        hit_d   = 1'b0;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef TONE_DEC_DEBUG_EN
        miss_d = miss_q;
        if (miss_c && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 1'b1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            cand_q    <= '0;
            run_q     <= '0;
            note_q    <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef TONE_DEC_DEBUG_EN
            miss_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
`ifdef TONE_DEC_DEBUG_EN
            miss_q    <= miss_d;
`endif
        end
    end

    assign note        = note_q;
    assign note_valid  = valid_q;
    assign note_strobe = strobe_q;
`ifdef TONE_DEC_DEBUG_EN
    assign period_raw  = period_q;
    assign miss_cnt    = miss_q;
`endif

endmodule
